multicycle_control_fsm: RTL

Multi-cycle sequencer for the MIPS datapath, replacing the single-cycle opcode decoder when instruction fetch, data access and ALU share one unified memory port and one ALU. Each instruction is stepped through fetch, decode, execute, memory and writeback states. Per state, the block drives the datapath mux selects and register write enables. Every memory access stalls on a ready handshake from the memory. Instruction set: R-type, addi, andi, ori, lw, lh, lhu, sw, beq.

---
 rtl/multicycle_control_fsm.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multi-cycle MIPS control sequencer. Steps each instruction
//               through fetch/decode/execute/memory/writeback, driving the
//               datapath selects and write enables, and stalling every
//               unified-memory access until MemReady.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic       LoadHalf,
  output logic       LoadHalfUnsigned,
  output logic       InstrRetired,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_LOAD  = 4'd4,
    S_LOAD_WB   = 4'd5,
    S_MEM_STORE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_ILLEGAL   = 4'd15
  } state_t;

  state_t state;
  state_t state_next;

  // State register; reset wins over any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode; everything defaults to idle.
  always_comb begin
    state_next       = state;
    PCWrite          = 1'b0;
    PCSrc            = 1'b0;
    IRWrite          = 1'b0;
    IorD             = 1'b0;
    MemRead          = 1'b0;
    MemWrite         = 1'b0;
    RegWrite         = 1'b0;
    RegDst           = 1'b0;
    MemtoReg         = 1'b0;
    ALUSrcA          = 1'b0;
    ALUSrcB          = 2'd0;
    ALUop            = 3'd0;
    LoadHalf         = 1'b0;
    LoadHalfUnsigned = 1'b0;
    InstrRetired     = 1'b0;
    IllegalOp        = 1'b0;

    case (state)
      S_INIT: begin
        state_next = S_FETCH;
      end

      // PC+4 is computed while the instruction word is read.
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_next = S_DECODE;
      end

      // ALUOut latches the branch target speculatively.
      S_DECODE: begin
        ALUSrcB = 2'd3;
        case (OPCode)
          OP_RTYPE:                state_next = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
          OP_LW, OP_LH, OP_LHU,
          OP_SW:                   state_next = S_MEM_ADDR;
          OP_BEQ:                  state_next = S_BRANCH;
          default:                 state_next = S_ILLEGAL;
        endcase
      end

      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        state_next = (OPCode == OP_SW) ? S_MEM_STORE : S_MEM_LOAD;
      end

      S_MEM_LOAD: begin
        MemRead          = 1'b1;
        IorD             = 1'b1;
        LoadHalf         = (OPCode == OP_LH);
        LoadHalfUnsigned = (OPCode == OP_LHU);
        if (MemReady) state_next = S_LOAD_WB;
      end

      S_LOAD_WB: begin
        RegWrite         = 1'b1;
        MemtoReg         = 1'b1;
        LoadHalf         = (OPCode == OP_LH);
        LoadHalfUnsigned = (OPCode == OP_LHU);
        InstrRetired     = 1'b1;
        state_next       = S_FETCH;
      end

      // A store retires on the cycle its write is accepted.
      S_MEM_STORE: begin
        MemWrite     = 1'b1;
        IorD         = 1'b1;
        InstrRetired = MemReady;
        if (MemReady) state_next = S_FETCH;
      end

      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUop      = 3'd2;
        state_next = S_R_WB;
      end

      S_R_WB: begin
        RegWrite     = 1'b1;
        RegDst       = 1'b1;
        InstrRetired = 1'b1;
        state_next   = S_FETCH;
      end

      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        case (OPCode)
          OP_ANDI: ALUop = 3'd4;
          OP_ORI:  ALUop = 3'd5;
          default: ALUop = 3'd3;
        endcase
        state_next = S_I_WB;
      end

      S_I_WB: begin
        RegWrite     = 1'b1;
        InstrRetired = 1'b1;
        state_next   = S_FETCH;
      end

      // Compare A-B; the target already sits in ALUOut from DECODE.
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUop        = 3'd1;
        PCSrc        = 1'b1;
        PCWrite      = Zero;
        InstrRetired = 1'b1;
        state_next   = S_FETCH;
      end

      // Halt with no side effects until reset.
      S_ILLEGAL: begin
        IllegalOp  = 1'b1;
        state_next = S_ILLEGAL;
      end

      // Unused encodings recover through INIT.
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  assign State = state;

endmodule
`default_nettype wire
